// File: rtl/apb_gpio_master.sv
// APB initiator for the GPIO controller register file: turns valid/ready commands into
// single SETUP/ACCESS transfers, with wait-state absorption and an optional hang timeout.
module apb_gpio_master #(
    parameter int PADDR_SIZE = 4,
    parameter int PDATA_SIZE = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    clk_in1,
    input  logic                    reset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [PADDR_SIZE-1:0]   cmd_addr,
    input  logic [PDATA_SIZE-1:0]   cmd_wdata,
    input  logic [PDATA_SIZE/8-1:0] cmd_strb,
    output logic                    rsp_valid,
    output logic [PDATA_SIZE-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [PADDR_SIZE-1:0]   PADDR,
    output logic [PDATA_SIZE-1:0]   PWDATA,
    output logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [PDATA_SIZE-1:0]   PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    // Counter keeps at least one bit so TIMEOUT=0 (timeout disabled) still elaborates.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t        state;
    logic [CW-1:0] wait_cnt;

    assign cmd_ready = (state == IDLE);

    always_ff @(posedge clk_in1) begin
        if (!reset) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            PSEL        <= 1'b0;
            PENABLE     <= 1'b0;
            PWRITE      <= 1'b0;
            PADDR       <= '0;
            PWDATA      <= '0;
            PSTRB       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        PWRITE <= cmd_write;
                        PADDR  <= cmd_addr;
                        PWDATA <= cmd_wdata;
                        PSTRB  <= cmd_write ? cmd_strb : '0;
                        PSEL   <= 1'b1;
                        state  <= SETUP;
                    end
                end
                SETUP: begin
                    PENABLE  <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= PWRITE ? '0 : PRDATA;
                        rsp_err     <= PSLVERR;
                        rsp_timeout <= 1'b0;
                        state       <= IDLE;
                    end else if (TIMEOUT != 0 && wait_cnt == TO_LAST) begin
                        // This edge closes the last allowed PREADY-low cycle.
                        PSEL        <= 1'b0;
                        PENABLE     <= 1'b0;
                        rsp_valid   <= 1'b1;
                        rsp_rdata   <= '0;
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        state       <= IDLE;
                    end else if (wait_cnt != '1) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    PSEL    <= 1'b0;
                    PENABLE <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule
